// File: rtl/bus_arbiter_pkg.sv
// Shared types and default widths for the bus_arbiter block.
package bus_arbiter_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OWNER_FETCH,
    OWNER_MEM
  } owner_t;

endpackage

// File: rtl/bus_arbiter.sv
// Two-requester arbiter (instruction fetch and load/store) in front of a
// single external bus with one outstanding transaction. The memory side
// wins when both ask in the same cycle. Once a request is latched it runs
// to completion on the bus; a response whose requester has since moved on
// is dropped instead of being handed back.
// Optional feature: define BUS_ARBITER_ERROR_EN to add ext_resp_error and
// the fetch_error / mem_error outputs.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    fetch_request,
  input  logic [ADDR_WIDTH-1:0]   fetch_address,
  output logic [DATA_WIDTH-1:0]   fetch_data,
  output logic                    fetch_ready,
  input  logic                    mem_request,
  input  logic                    mem_write,
  input  logic [ADDR_WIDTH-1:0]   mem_address,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_strb,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_ready,
  output logic                    ext_valid,
  input  logic                    ext_ready,
  output logic [ADDR_WIDTH-1:0]   ext_address,
  output logic                    ext_write,
  output logic [DATA_WIDTH-1:0]   ext_wdata,
  output logic [DATA_WIDTH/8-1:0] ext_strb,
  input  logic                    ext_resp_valid,
  input  logic [DATA_WIDTH-1:0]   ext_rdata
`ifdef BUS_ARBITER_ERROR_EN
  ,
  input  logic                    ext_resp_error,
  output logic                    fetch_error,
  output logic                    mem_error
`endif
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t                  r_state;
  owner_t                  r_owner;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_WIDTH-1:0]   r_strb;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_ext_valid;
`ifdef BUS_ARBITER_ERROR_EN
  logic                    r_err;
`endif

  logic w_resp;

  // Arbitration FSM: latch the winning request, present it until the bus takes it, then capture the response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_owner     <= OWNER_FETCH;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_strb      <= '0;
      r_rdata     <= '0;
      r_ext_valid <= 1'b0;
`ifdef BUS_ARBITER_ERROR_EN
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (mem_request) begin
            r_owner     <= OWNER_MEM;
            r_addr      <= mem_address;
            r_write     <= mem_write;
            r_wdata     <= mem_wdata;
            r_strb      <= mem_strb;
            r_ext_valid <= 1'b1;
            r_state     <= REQ;
          end else if (fetch_request) begin
            r_owner     <= OWNER_FETCH;
            r_addr      <= fetch_address;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_strb      <= '1;
            r_ext_valid <= 1'b1;
            r_state     <= REQ;
          end
        end
        REQ: begin
          if (ext_ready) begin
            r_ext_valid <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (ext_resp_valid) begin
            r_rdata <= ext_rdata;
`ifdef BUS_ARBITER_ERROR_EN
            r_err   <= ext_resp_error;
`endif
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state     <= IDLE;
          r_ext_valid <= 1'b0;
        end
      endcase
    end
  end

  assign w_resp = (r_state == RESP);

  assign ext_valid   = r_ext_valid;
  assign ext_address = r_addr;
  assign ext_write   = r_write;
  assign ext_wdata   = r_wdata;
  assign ext_strb    = r_strb;

  assign fetch_ready = w_resp && (r_owner == OWNER_FETCH) && fetch_request &&
                       (fetch_address == r_addr);
  assign mem_ready   = w_resp && (r_owner == OWNER_MEM) && mem_request;

  assign fetch_data = r_rdata;
  assign mem_rdata  = r_rdata;

`ifdef BUS_ARBITER_ERROR_EN
  assign fetch_error = fetch_ready && r_err;
  assign mem_error   = mem_ready && r_err;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// single transactions checked against expectations derived from the
// arbitration rules (memory wins ties, fetch gets all-ones strobes, a
// response is returned only to a requester still asking for it).
module tb_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          fetch_request;
  logic [AW-1:0] fetch_address;
  logic [DW-1:0] fetch_data;
  logic          fetch_ready;
  logic          mem_request;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_strb;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          ext_valid;
  logic          ext_ready;
  logic [AW-1:0] ext_address;
  logic          ext_write;
  logic [DW-1:0] ext_wdata;
  logic [SW-1:0] ext_strb;
  logic          ext_resp_valid;
  logic [DW-1:0] ext_rdata;
`ifdef BUS_ARBITER_ERROR_EN
  logic          ext_resp_error;
  logic          fetch_error;
  logic          mem_error;
`endif

  int total = 0;
  int bad = 0;

  bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_request(fetch_request), .fetch_address(fetch_address),
    .fetch_data(fetch_data), .fetch_ready(fetch_ready),
    .mem_request(mem_request), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_strb(mem_strb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_address(ext_address),
    .ext_write(ext_write), .ext_wdata(ext_wdata), .ext_strb(ext_strb),
    .ext_resp_valid(ext_resp_valid), .ext_rdata(ext_rdata)
`ifdef BUS_ARBITER_ERROR_EN
    , .ext_resp_error(ext_resp_error), .fetch_error(fetch_error), .mem_error(mem_error)
`endif
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    fetch_request  = 1'b0;
    fetch_address  = '0;
    mem_request    = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_wdata      = '0;
    mem_strb       = '0;
    ext_ready      = 1'b0;
    ext_resp_valid = 1'b0;
    ext_rdata      = '0;
`ifdef BUS_ARBITER_ERROR_EN
    ext_resp_error = 1'b0;
`endif
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clearInputs();
    ext_resp_valid = 1'b1;
    ext_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    total++; if (ext_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_ext_valid: got %0h want 0", ext_valid); end
    total++; if (fetch_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_fetch_ready: got %0h want 0", fetch_ready); end
    total++; if (mem_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_ready: got %0h want 0", mem_ready); end
    total++; if (ext_write !== 1'b0) begin bad++; $display("[TB] FAIL reset_ext_write: got %0h want 0", ext_write); end
    total++; if (ext_address !== 32'h0) begin bad++; $display("[TB] FAIL reset_ext_address: got %h want 0", ext_address); end
    total++; if (ext_strb !== 4'h0) begin bad++; $display("[TB] FAIL reset_ext_strb: got %h want 0", ext_strb); end
    total++; if (ext_wdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_ext_wdata: got %h want 0", ext_wdata); end
    total++; if (fetch_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_fetch_data: got %h want 0", fetch_data); end
    reset_n = 1'b1;
    ext_resp_valid = 1'b0;
    ext_rdata = '0;
    tick();
  endtask

  task automatic test_fetch_basic();
    fetch_request = 1'b1;
    fetch_address = 32'h100;
    ext_ready = 1'b1;
    @(negedge clk);
    total++; if (ext_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_c0_valid: got %0h want 0", ext_valid); end
    tick();
    @(negedge clk);
    total++; if (ext_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_c1_valid: got %0h want 1", ext_valid); end
    total++; if (ext_address !== 32'h100) begin bad++; $display("[TB] FAIL basic_c1_addr: got %h want 100", ext_address); end
    total++; if (ext_write !== 1'b0) begin bad++; $display("[TB] FAIL basic_c1_write: got %0h want 0", ext_write); end
    total++; if (ext_strb !== 4'hF) begin bad++; $display("[TB] FAIL basic_c1_strb: got %h want f", ext_strb); end
    tick();
    ext_ready = 1'b0;
    ext_resp_valid = 1'b1;
    ext_rdata = 32'h0000_0013;
    @(negedge clk);
    total++; if (ext_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_c2_valid: got %0h want 0", ext_valid); end
    total++; if (fetch_ready !== 1'b0) begin bad++; $display("[TB] FAIL basic_c2_ready: got %0h want 0", fetch_ready); end
    tick();
    ext_resp_valid = 1'b0;
    ext_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("[TB] FAIL basic_c3_ready: got %0h want 1", fetch_ready); end
    total++; if (fetch_data !== 32'h13) begin bad++; $display("[TB] FAIL basic_c3_data: got %h want 13", fetch_data); end
    total++; if (mem_ready !== 1'b0) begin bad++; $display("[TB] FAIL basic_c3_mem_ready: got %0h want 0", mem_ready); end
    tick();
    clearInputs();
    @(negedge clk);
    total++; if (fetch_ready !== 1'b0) begin bad++; $display("[TB] FAIL basic_c4_ready: got %0h want 0", fetch_ready); end
    tick();
  endtask

  task automatic test_priority();
    fetch_request = 1'b1;
    fetch_address = 32'h100;
    mem_request = 1'b1;
    mem_write = 1'b0;
    mem_address = 32'h2000;
    mem_strb = 4'hF;
    tick();
    ext_ready = 1'b1;
    @(negedge clk);
    total++; if (ext_address !== 32'h2000) begin bad++; $display("[TB] FAIL prio_first_addr: got %h want 2000", ext_address); end
    tick();
    ext_ready = 1'b0;
    ext_resp_valid = 1'b1;
    ext_rdata = 32'hAAAA_0001;
    tick();
    ext_resp_valid = 1'b0;
    @(negedge clk);
    total++; if (mem_ready !== 1'b1) begin bad++; $display("[TB] FAIL prio_mem_ready: got %0h want 1", mem_ready); end
    total++; if (mem_rdata !== 32'hAAAA_0001) begin bad++; $display("[TB] FAIL prio_mem_data: got %h want aaaa0001", mem_rdata); end
    total++; if (fetch_ready !== 1'b0) begin bad++; $display("[TB] FAIL prio_fetch_early: got %0h want 0", fetch_ready); end
    tick();
    mem_request = 1'b0;
    tick();
    ext_ready = 1'b1;
    @(negedge clk);
    total++; if (ext_address !== 32'h100) begin bad++; $display("[TB] FAIL prio_second_addr: got %h want 100", ext_address); end
    total++; if (ext_strb !== 4'hF) begin bad++; $display("[TB] FAIL prio_second_strb: got %h want f", ext_strb); end
    tick();
    ext_ready = 1'b0;
    ext_resp_valid = 1'b1;
    ext_rdata = 32'hBBBB_0002;
    tick();
    ext_resp_valid = 1'b0;
    @(negedge clk);
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("[TB] FAIL prio_fetch_ready: got %0h want 1", fetch_ready); end
    total++; if (fetch_data !== 32'hBBBB_0002) begin bad++; $display("[TB] FAIL prio_fetch_data: got %h want bbbb0002", fetch_data); end
    tick();
    clearInputs();
    tick();
  endtask

  task automatic test_write_stall();
    mem_request = 1'b1;
    mem_write = 1'b1;
    mem_address = 32'h3004;
    mem_wdata = 32'hDEAD_BEEF;
    mem_strb = 4'b0011;
    tick();
    for (int i = 0; i < 5; i++) begin
      ext_ready = (i == 4);
      @(negedge clk);
      total++; if (ext_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_valid[%0d]: got %0h want 1", i, ext_valid); end
      total++; if ({ext_address, ext_write, ext_wdata, ext_strb} !== {32'h3004, 1'b1, 32'hDEAD_BEEF, 4'b0011}) begin
        bad++; $display("[TB] FAIL stall_fields[%0d]: got %h/%0h/%h/%h want 3004/1/deadbeef/3", i, ext_address, ext_write, ext_wdata, ext_strb);
      end
      tick();
    end
    ext_ready = 1'b0;
    @(negedge clk);
    total++; if (mem_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_wait_ready: got %0h want 0", mem_ready); end
    tick();
    ext_resp_valid = 1'b1;
    tick();
    ext_resp_valid = 1'b0;
    @(negedge clk);
    total++; if (mem_ready !== 1'b1) begin bad++; $display("[TB] FAIL stall_mem_ready: got %0h want 1", mem_ready); end
    tick();
    clearInputs();
    tick();
  endtask

  task automatic test_stale_fetch();
    fetch_request = 1'b1;
    fetch_address = 32'h100;
    ext_ready = 1'b1;
    tick();
    tick();
    ext_ready = 1'b0;
    fetch_address = 32'h200;
    ext_resp_valid = 1'b1;
    ext_rdata = 32'h0000_0013;
    tick();
    ext_resp_valid = 1'b0;
    @(negedge clk);
    total++; if (fetch_ready !== 1'b0) begin bad++; $display("[TB] FAIL stale_dropped: got %0h want 0", fetch_ready); end
    tick();
    tick();
    ext_ready = 1'b1;
    @(negedge clk);
    total++; if (ext_valid !== 1'b1) begin bad++; $display("[TB] FAIL stale_refetch_valid: got %0h want 1", ext_valid); end
    total++; if (ext_address !== 32'h200) begin bad++; $display("[TB] FAIL stale_refetch_addr: got %h want 200", ext_address); end
    tick();
    ext_ready = 1'b0;
    ext_resp_valid = 1'b1;
    ext_rdata = 32'h0000_0055;
    tick();
    ext_resp_valid = 1'b0;
    @(negedge clk);
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("[TB] FAIL stale_new_ready: got %0h want 1", fetch_ready); end
    total++; if (fetch_data !== 32'h55) begin bad++; $display("[TB] FAIL stale_new_data: got %h want 55", fetch_data); end
    tick();
    clearInputs();
    tick();
  endtask

  task automatic test_reset_mid();
    fetch_request = 1'b1;
    fetch_address = 32'h440;
    ext_ready = 1'b1;
    tick();
    tick();
    ext_ready = 1'b0;
    reset_n = 1'b0;
    fetch_request = 1'b0;
    #2;
    total++; if (ext_address !== 32'h0) begin bad++; $display("[TB] FAIL midrst_addr: got %h want 0", ext_address); end
    total++; if (ext_strb !== 4'h0) begin bad++; $display("[TB] FAIL midrst_strb: got %h want 0", ext_strb); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      ext_resp_valid = 1'b1;
      ext_rdata = 32'h1234_5678;
      @(negedge clk);
      total++; if ({ext_valid, fetch_ready, mem_ready} !== 3'b000) begin
        bad++; $display("[TB] FAIL midrst_late_resp[%0d]: got %b want 000", i, {ext_valid, fetch_ready, mem_ready});
      end
      tick();
    end
    clearInputs();
    tick();
  endtask

`ifdef BUS_ARBITER_ERROR_EN
  task automatic test_error();
    mem_request = 1'b1;
    mem_address = 32'h2200;
    mem_strb = 4'hF;
    ext_ready = 1'b1;
    tick();
    tick();
    ext_ready = 1'b0;
    ext_resp_valid = 1'b1;
    ext_resp_error = 1'b1;
    tick();
    ext_resp_valid = 1'b0;
    ext_resp_error = 1'b0;
    @(negedge clk);
    total++; if ({mem_ready, mem_error, fetch_error} !== 3'b110) begin
      bad++; $display("[TB] FAIL err_mem: got %b want 110", {mem_ready, mem_error, fetch_error});
    end
    tick();
    clearInputs();
    @(negedge clk);
    total++; if (mem_error !== 1'b0) begin bad++; $display("[TB] FAIL err_idle: got %0h want 0", mem_error); end
    tick();
  endtask
`endif

  // Random single transactions; the expected bus fields and the final
  // ready are worked out from the arbitration rules before driving.
  task automatic test_random_traffic();
    for (int n = 0; n < 60; n++) begin
      bit            doMem, doFetch, expMemWin, expReady;
      logic [AW-1:0] fAddr, mAddr, expAddr;
      logic [DW-1:0] wData, rData;
      logic [SW-1:0] mStrb, expStrb;
      logic          mWrite, expWrite;
      int            readyDelay, respDelay, dropMode;
      bit            accepted;
      int            cyc;

      doMem      = ($urandom_range(0, 1) == 1);
      doFetch    = !doMem || ($urandom_range(0, 1) == 1);
      fAddr      = $urandom() & 32'hFFFF_FFFC;
      mAddr      = $urandom() & 32'hFFFF_FFFC;
      wData      = $urandom();
      rData      = $urandom();
      mStrb      = 4'($urandom_range(1, 15));
      mWrite     = ($urandom_range(0, 1) == 1);
      readyDelay = $urandom_range(0, 3);
      respDelay  = $urandom_range(0, 3);
      dropMode   = $urandom_range(0, 3);

      expMemWin = doMem;
      expAddr   = doMem ? mAddr : fAddr;
      expWrite  = doMem ? mWrite : 1'b0;
      expStrb   = doMem ? mStrb : 4'hF;
      expReady  = (dropMode < 2);

      fetch_request = doFetch;
      fetch_address = fAddr;
      mem_request   = doMem;
      mem_address   = mAddr;
      mem_write     = mWrite;
      mem_wdata     = wData;
      mem_strb      = mStrb;
      @(negedge clk);
      total++; if ({ext_valid, fetch_ready, mem_ready} !== 3'b000) begin
        bad++; $display("[TB] FAIL rnd%0d_idle: got %b want 000", n, {ext_valid, fetch_ready, mem_ready});
      end
      tick();

      accepted = 1'b0;
      cyc = 0;
      while (!accepted && cyc < 8) begin
        ext_ready = (cyc == readyDelay);
        if (dropMode == 2 && cyc == 0) begin
          if (expMemWin) mem_request = 1'b0;
          else if ($urandom_range(0, 1) == 1) fetch_request = 1'b0;
          else fetch_address = fAddr ^ 32'h4;
        end
        @(negedge clk);
        total++; if (ext_valid !== 1'b1) begin bad++; $display("[TB] FAIL rnd%0d_valid: got %0h want 1", n, ext_valid); end
        total++; if ({ext_address, ext_write, ext_strb} !== {expAddr, expWrite, expStrb}) begin
          bad++; $display("[TB] FAIL rnd%0d_fields: got %h/%0h/%h want %h/%0h/%h", n, ext_address, ext_write, ext_strb, expAddr, expWrite, expStrb);
        end
        if (expMemWin) begin
          total++; if (ext_wdata !== wData) begin bad++; $display("[TB] FAIL rnd%0d_wdata: got %h want %h", n, ext_wdata, wData); end
        end
        tick();
        accepted = ext_ready;
        cyc++;
      end
      ext_ready = 1'b0;

      if (dropMode == 3) begin
        if (expMemWin) mem_request = 1'b0;
        else if ($urandom_range(0, 1) == 1) fetch_request = 1'b0;
        else fetch_address = fAddr ^ 32'h8;
      end
      for (int d = 0; d <= respDelay; d++) begin
        ext_resp_valid = (d == respDelay);
        ext_rdata = (d == respDelay) ? rData : DW'($urandom());
        @(negedge clk);
        total++; if ({ext_valid, fetch_ready, mem_ready} !== 3'b000) begin
          bad++; $display("[TB] FAIL rnd%0d_wait: got %b want 000", n, {ext_valid, fetch_ready, mem_ready});
        end
        tick();
      end
      ext_resp_valid = 1'b0;
      ext_rdata = $urandom();

      @(negedge clk);
      total++; if (mem_ready !== (expMemWin && expReady)) begin
        bad++; $display("[TB] FAIL rnd%0d_mem_ready: got %0h want %0h", n, mem_ready, expMemWin && expReady);
      end
      total++; if (fetch_ready !== (!expMemWin && expReady)) begin
        bad++; $display("[TB] FAIL rnd%0d_fetch_ready: got %0h want %0h", n, fetch_ready, !expMemWin && expReady);
      end
      if (expReady) begin
        total++; if ((expMemWin ? mem_rdata : fetch_data) !== rData) begin
          bad++; $display("[TB] FAIL rnd%0d_rdata: got %h want %h", n, expMemWin ? mem_rdata : fetch_data, rData);
        end
      end
      tick();
      clearInputs();
    end
    tick();
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    clearInputs();
    test_reset();
    test_fetch_basic();
    test_priority();
    test_write_stall();
    test_stale_fetch();
    test_reset_mid();
`ifdef BUS_ARBITER_ERROR_EN
    test_error();
`endif
    test_random_traffic();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
